seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned divider. It computes quotient and remainder by repeated trial subtraction, one quotient bit per clock.
- It is the inverse companion to the team's combinational add/subtract datapath. It shares the 5-bit operand width and the same xor/carry-based subtract formulation.
- It sits behind a start/done handshake, so a controller can issue divisions and collect results without a combinational path through the arithmetic.

Parameters:
- WIDTH, 5, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only when the block is not busy.
- a  input  WIDTH  unsigned dividend; captured on the accepted start edge.
- b  input  WIDTH  unsigned divisor; captured on the accepted start edge.
- q  output  WIDTH  quotient; valid from the done cycle, held until the next completion.
- r  output  WIDTH  remainder; valid from the done cycle, held until the next completion.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse marking the cycle in which q/r/dz first hold the new result.
- dz  output  1  divide-by-zero flag for the current result; held with q/r.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - q, r, busy, done, dz, iteration counter and all internal registers = 0.
  - Reset is effective immediately, including mid-division. The in-flight operation is discarded and no done pulse is issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and b!=0: latch a into the dividend shift register, latch b into the divisor register, clear the partial remainder (WIDTH+1 bits), load counter = WIDTH, busy=1. Next state RUN.
  - If start=1 and b==0: next state DONE. On that edge, load q = all ones (31 for WIDTH=5), r = a, dz = 1.
  - Otherwise stay in IDLE.
- RUN, one edge per quotient bit, MSB first:
  - trial = {rem[WIDTH-1:0], dividend MSB} minus {0, divisor}, computed WIDTH+1 bits wide. The subtraction is add-with-inverted-divisor plus carry-in 1.
  - Carry-out 1 (no borrow): rem = trial, quotient bit = 1.
  - Otherwise: rem = the shifted value, quotient bit = 0.
  - The dividend shifts left with the quotient bit entering at the LSB. The counter decrements.
  - On the edge where the counter reaches 0: q = quotient register, r = rem[WIDTH-1:0], dz = 0, busy = 0. Next state DONE.
- DONE:
  - done = 1 for exactly this one cycle; busy = 0.
  - start is honoured here exactly as in IDLE, so back-to-back operations are allowed. Otherwise next state is IDLE.
- Latency:
  - Nonzero divisor: done is high in the cycle beginning WIDTH+1 edges after the accepted start edge (6 for WIDTH=5).
  - Zero divisor: done follows 1 edge after the accepted start edge.
- busy is high from the edge after start is accepted until the final RUN edge, inclusive. busy is never high together with done.
- start while in RUN is ignored, and a/b changes in RUN have no effect (operands are latched).
- q, r and dz change only on completion edges and on reset. They are stable during RUN, so a new operation does not disturb the previous result until it completes.
- Invariant for b!=0: a == q*b + r and r < b.
- Boundary cases: a=0 gives q=0, r=0; a<b gives q=0, r=a; b=1 gives q=a, r=0.

Test Plan:
- Reset, then start with a=23, b=5 → busy=1 for 5 cycles; done pulses on the 6th edge after start; q=4, r=3, dz=0.
- a=31, b=1 → q=31, r=0. Then a=7, b=9 → q=0, r=7. Then a=0, b=3 → q=0, r=0. Each done pulse is exactly one cycle wide.
- a=13, b=0 → done on the next edge, busy never set, q=31, r=13, dz=1. A following a=12, b=4 clears dz, giving q=3, r=0.
- Start a=30, b=7, then pulse start with a=5, b=1 at RUN cycle 2 → second request ignored; result q=4, r=2. Then assert start during the done cycle with a=9, b=2 → accepted; q=4, r=1 after 6 more edges.
- Start a=29, b=3, drop rst_n at RUN cycle 3 (between clock edges) → q, r, busy, done, dz go to 0 immediately. No done pulse follows, and the next start (a=29, b=3) returns q=9, r=2.
- Exhaustive sweep of all a, b in 0..31 against a reference model checks the invariant, the dz rule and the fixed latency for each case.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/operand request and result/status bundle for the divider
interface seq_restoring_divider_if #(parameter int WIDTH = 5);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dz;
  modport master (output start, a, b, input q, r, busy, done, dz);
  modport slave  (input start, a, b, output q, r, busy, done, dz);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(parameter int WIDTH = 5) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, qo_q, qo_d, ro_q, ro_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0]   shifted, trial;
  logic             cout;
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    // subtract as add of the inverted, zero-extended divisor with carry-in 1; carry-out 1 means no borrow
    {cout, trial} = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + (WIDTH+2)'(1);
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (state_q == RUN) begin
      dvd_d  = {dvd_q[WIDTH-2:0], cout};
      rem_d  = cout ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      cnt_d  = cnt_q - CW'(1);
      busy_d = cnt_q != CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        done_d  = 1'b1;
        qo_d    = dvd_d;
        ro_d    = rem_d;
        dz_d    = 1'b0;
      end
    end else if (bus.start && bus.b != '0) begin
      state_d = RUN;
      dvd_d   = bus.a;
      dvs_d   = bus.b;
      rem_d   = '0;
      cnt_d   = CW'(WIDTH);
      busy_d  = 1'b1;
    end else if (bus.start) begin
      state_d = DONE;
      done_d  = 1'b1;
      qo_d    = '1;
      ro_d    = bus.a;
      dz_d    = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign bus.q    = qo_q;
  assign bus.r    = ro_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and exhaustive checks of the sequential divider
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;
  int   lat, bc, ovl;
  seq_restoring_divider_if #(.WIDTH(5)) bus ();
  seq_restoring_divider #(.WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.busy) bc++;
    if (bus.busy && bus.done) ovl++;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [4:0] ea, input logic [4:0] eb);
    bus.a = ea;
    bus.b = eb;
    bus.start = 1'b1;
    bc = 0;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
  endtask
  task automatic res(input string tag, input int eq, input int er, input int edz, input int elat);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".q"}, int'(bus.q), eq);
    chk({tag, ".r"}, int'(bus.r), er);
    chk({tag, ".dz"}, int'(bus.dz), edz);
  endtask
  initial begin
    ovl = 0;
    bc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    chk("rst.q", int'(bus.q), 0);
    chk("rst.r", int'(bus.r), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.done", int'(bus.done), 0);
    chk("rst.dz", int'(bus.dz), 0);
    rst_n = 1'b1;
    tick();
    go(5'd23, 5'd5);
    res("23/5", 4, 3, 0, 6);
    chk("23/5.busy_cycles", bc, 5);
    tick();
    chk("23/5.pulse", int'(bus.done), 0);
    go(5'd31, 5'd1);
    res("31/1", 31, 0, 0, 6);
    tick();
    chk("31/1.pulse", int'(bus.done), 0);
    go(5'd7, 5'd9);
    res("7/9", 0, 7, 0, 6);
    tick();
    chk("7/9.pulse", int'(bus.done), 0);
    go(5'd0, 5'd3);
    res("0/3", 0, 0, 0, 6);
    tick();
    chk("0/3.pulse", int'(bus.done), 0);
    go(5'd13, 5'd0);
    res("13/0", 31, 13, 1, 1);
    chk("13/0.busy_cycles", bc, 0);
    tick();
    chk("13/0.pulse", int'(bus.done), 0);
    go(5'd12, 5'd4);
    res("12/4", 3, 0, 0, 6);
    tick();
    bus.a = 5'd30;
    bus.b = 5'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 5'd5;
    bus.b = 5'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("30/7.hold_q", int'(bus.q), 3);
    lat = 3;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    res("30/7", 4, 2, 0, 6);
    go(5'd9, 5'd2);
    res("9/2", 4, 1, 0, 6);
    tick();
    bus.a = 5'd29;
    bus.b = 5'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.q", int'(bus.q), 0);
    chk("arst.r", int'(bus.r), 0);
    chk("arst.busy", int'(bus.busy), 0);
    chk("arst.done", int'(bus.done), 0);
    chk("arst.dz", int'(bus.dz), 0);
    tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) lat++;
    end
    chk("arst.no_done", lat, 0);
    go(5'd29, 5'd3);
    res("29/3", 9, 2, 0, 6);
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        go(5'(x), 5'(y));
        if (y == 0) begin
          res($sformatf("sw%0d/%0d", x, y), 31, x, 1, 1);
        end else begin
          res($sformatf("sw%0d/%0d", x, y), x / y, x % y, 0, 6);
          chk($sformatf("sw%0d/%0d.inv", x, y), int'(bus.q) * y + int'(bus.r), x);
        end
      end
    end
    chk("busy_done_overlap", ovl, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
